// File: rtl/bandwidth_regulator_pkg.sv
// Shared types for the per-queue bandwidth regulator: value widths, config and budget FSM states.
// Optional statistics are enabled with the REGULATOR_STATS_EN macro.
package memoredf_regulator_pkg;

    localparam int DEF_NUMBER_OF_QUEUES = 4;
    localparam int DEF_REGISTER_SIZE    = 32;
    localparam int DEF_STAT_SIZE        = 16;

    typedef logic [DEF_REGISTER_SIZE-1:0] budget_t;
    typedef logic [DEF_STAT_SIZE-1:0]     stat_t;

    typedef enum logic {
        IDLE,
        PENDING
    } cfg_state_e;

    typedef enum logic [1:0] {
        FULL,
        PARTIAL,
        EXHAUSTED
    } budget_state_e;

endpackage

// File: rtl/bandwidth_regulator_if.sv
// Bus between the queue scheduler side and the bandwidth regulator.
// exhaust_count only exists when REGULATOR_STATS_EN is defined.
interface bandwidth_regulator_if
    import memoredf_regulator_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES = DEF_NUMBER_OF_QUEUES,
    parameter int REGISTER_SIZE    = DEF_REGISTER_SIZE
`ifdef REGULATOR_STATS_EN
    ,
    parameter int STAT_SIZE        = DEF_STAT_SIZE
`endif
) ();

    // Config handshake: a set transfers on a cycle where cfg_valid and cfg_ready are both 1;
    // the offerer holds cfg_period/cfg_budgets stable while cfg_valid is high and unaccepted.
    logic                                  enable;
    logic [NUMBER_OF_QUEUES-1:0]           consumed;
    logic                                  cfg_valid;
    logic                                  cfg_ready;
    logic [REGISTER_SIZE-1:0]              cfg_period;
    logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] cfg_budgets;
    logic [NUMBER_OF_QUEUES-1:0]           throttle;
    logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] remaining;
    logic                                  window_tick;
    cfg_state_e                            cfg_state;
    budget_state_e [NUMBER_OF_QUEUES-1:0]  budget_state;
`ifdef REGULATOR_STATS_EN
    logic [NUMBER_OF_QUEUES*STAT_SIZE-1:0] exhaust_count;
`endif

    modport slave (
        input  enable, consumed, cfg_valid, cfg_period, cfg_budgets,
        output cfg_ready, throttle, remaining, window_tick, cfg_state, budget_state
`ifdef REGULATOR_STATS_EN
        , output exhaust_count
`endif
    );

    modport master (
        output enable, consumed, cfg_valid, cfg_period, cfg_budgets,
        input  cfg_ready, throttle, remaining, window_tick, cfg_state, budget_state
`ifdef REGULATOR_STATS_EN
        , input exhaust_count
`endif
    );

endinterface

// File: rtl/bandwidth_regulator_budget_counter.sv
// One queue's remaining-budget counter with FULL/PARTIAL/EXHAUSTED tracking.
// The exhaust event output exists only when REGULATOR_STATS_EN is defined.
module budget_counter
    import memoredf_regulator_pkg::*;
#(
    parameter int WIDTH = DEF_REGISTER_SIZE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             consume,
    input  logic             enable,
    input  logic [WIDTH-1:0] budget,
`ifdef REGULATOR_STATS_EN
    output logic             exhaust,
`endif
    output logic [WIDTH-1:0] remaining,
    output logic             throttle,
    output budget_state_e    state
);

    budget_state_e    state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= FULL;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // Reload beats consumption; a zero budget can never reach EXHAUSTED because it never decrements.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        if (!enable || tick) begin
            state_d     = FULL;
            remaining_d = budget;
        end else if (consume && (remaining_q != '0)) begin
            remaining_d = remaining_q - WIDTH'(1);
            state_d     = (remaining_q == WIDTH'(1)) ? EXHAUSTED : PARTIAL;
        end
    end

`ifdef REGULATOR_STATS_EN
    assign exhaust   = enable && !tick && consume && (remaining_q == WIDTH'(1));
`endif
    assign remaining = remaining_q;
    assign throttle  = (state_q == EXHAUSTED);
    assign state     = state_q;

endmodule

// File: rtl/bandwidth_regulator.sv
// Per-queue memory-bandwidth regulator: window counter, shadowed config FSM, one budget counter per queue.
// Define REGULATOR_STATS_EN to add saturating per-queue exhaustion counters.
module bandwidth_regulator
    import memoredf_regulator_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES = DEF_NUMBER_OF_QUEUES,
    parameter int REGISTER_SIZE    = DEF_REGISTER_SIZE
`ifdef REGULATOR_STATS_EN
    ,
    parameter int STAT_SIZE        = DEF_STAT_SIZE
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    bandwidth_regulator_if.slave  bus
);

    localparam int N = NUMBER_OF_QUEUES;
    localparam int R = REGISTER_SIZE;

    cfg_state_e       cfg_state_q, cfg_state_d;
    logic [R-1:0]     period_q, shadow_period_q, cnt_q;
    logic [N*R-1:0]   budgets_q, shadow_budgets_q, load_budgets, remaining_w;
    logic [N-1:0]     throttle_w;
    budget_state_e [N-1:0] budget_state_w;
    logic             regulate, tick, apply, accept;

    assign regulate = bus.enable && (period_q != '0);
    assign tick     = regulate && (cnt_q == period_q - R'(1));
    // With regulation off there is no boundary to wait for, so a pending set applies at once.
    assign apply    = (cfg_state_q == PENDING) && (tick || (period_q == '0));
    assign load_budgets = apply ? shadow_budgets_q : budgets_q;

    always_comb begin
        cfg_state_d = cfg_state_q;
        accept      = 1'b0;
        case (cfg_state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    accept      = 1'b1;
                    cfg_state_d = PENDING;
                end
            end
            PENDING: begin
                if (apply) begin
                    cfg_state_d = IDLE;
                end
            end
            default: cfg_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cfg_state_q      <= IDLE;
            period_q         <= '0;
            budgets_q        <= '0;
            shadow_period_q  <= '0;
            shadow_budgets_q <= '0;
        end else begin
            cfg_state_q <= cfg_state_d;
            if (accept) begin
                shadow_period_q  <= bus.cfg_period;
                shadow_budgets_q <= bus.cfg_budgets;
            end
            if (apply) begin
                period_q  <= shadow_period_q;
                budgets_q <= shadow_budgets_q;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (!regulate || tick || apply) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + R'(1);
        end
    end

`ifdef REGULATOR_STATS_EN
    localparam int S = STAT_SIZE;
    logic [N-1:0]   exhaust_w;
    logic [N*S-1:0] exhaust_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exhaust_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (exhaust_w[i] && !(&exhaust_q[i*S +: S])) begin
                    exhaust_q[i*S +: S] <= exhaust_q[i*S +: S] + S'(1);
                end
            end
        end
    end

    assign bus.exhaust_count = exhaust_q;
`endif

    for (genvar i = 0; i < N; i++) begin : g_queue
        budget_counter #(
            .WIDTH(R)
        ) u_counter (
            .clock     (clock),
            .reset     (reset),
            .tick      (tick),
            .consume   (bus.consumed[i]),
            .enable    (regulate),
            .budget    (load_budgets[i*R +: R]),
`ifdef REGULATOR_STATS_EN
            .exhaust   (exhaust_w[i]),
`endif
            .remaining (remaining_w[i*R +: R]),
            .throttle  (throttle_w[i]),
            .state     (budget_state_w[i])
        );
    end

    assign bus.cfg_ready    = (cfg_state_q == IDLE);
    assign bus.window_tick  = tick;
    assign bus.cfg_state    = cfg_state_q;
    assign bus.remaining    = remaining_w;
    assign bus.throttle     = throttle_w;
    assign bus.budget_state = budget_state_w;

endmodule

// File: tb/tb_bandwidth_regulator.sv
// Bench for bandwidth_regulator: directed steps then random traffic, checked against a window/usage model.
// Statistics checks are compiled in when REGULATOR_STATS_EN is defined.
module tb_bandwidth_regulator;
    localparam int N = 4;
    localparam int R = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;

    bandwidth_regulator_if #(.NUMBER_OF_QUEUES(N), .REGISTER_SIZE(R)) bus ();

    bandwidth_regulator #(
        .NUMBER_OF_QUEUES(N),
        .REGISTER_SIZE   (R)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // stimulus state
    logic        en;
    logic [3:0]  cons;
    logic        cv;
    logic [31:0] cper;
    logic [31:0] cb [N];
    logic        obs_tick;

    // model: a window is m_period cycles long; m_used counts transactions charged this window
    int m_period, m_pos, sh_period;
    int m_budget [N];
    int m_used [N];
    int sh_budget [N];
    int m_exh [N];
    bit m_pending;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_period  = 0;
        m_pos     = 0;
        sh_period = 0;
        m_pending = 1'b0;
        for (int q = 0; q < N; q++) begin
            m_budget[q]  = 0;
            m_used[q]    = 0;
            sh_budget[q] = 0;
            m_exh[q]     = 0;
        end
    endtask

    function automatic bit model_tick();
        return en && (m_period != 0) && (m_pos == m_period - 1);
    endfunction

    task automatic model_step();
        bit reg_on, tk, ap, hs;
        reg_on = en && (m_period != 0);
        tk = model_tick();
        ap = m_pending && (tk || m_period == 0);
        hs = !m_pending && cv;
        if (!reg_on || tk) begin
            m_pos = 0;
            for (int q = 0; q < N; q++) m_used[q] = 0;
        end else begin
            m_pos++;
            for (int q = 0; q < N; q++) begin
                if (cons[q] && m_used[q] < m_budget[q]) begin
                    m_used[q]++;
                    if (m_used[q] == m_budget[q] && m_exh[q] < 65535) m_exh[q]++;
                end
            end
        end
        if (ap) begin
            m_period  = sh_period;
            m_pos     = 0;
            m_pending = 1'b0;
            for (int q = 0; q < N; q++) begin
                m_budget[q] = sh_budget[q];
                m_used[q]   = 0;
            end
        end
        if (hs) begin
            m_pending = 1'b1;
            sh_period = int'(cper);
            for (int q = 0; q < N; q++) sh_budget[q] = int'(cb[q]);
        end
    endtask

    task automatic check_state();
        for (int q = 0; q < N; q++) begin
            check($sformatf("remaining[%0d]", q), bus.remaining[q*R +: R], m_budget[q] - m_used[q]);
            check($sformatf("throttle[%0d]", q), 32'(bus.throttle[q]),
                  32'(m_budget[q] > 0 && m_used[q] == m_budget[q]));
`ifdef REGULATOR_STATS_EN
            check($sformatf("exhaust_count[%0d]", q), 32'(bus.exhaust_count[q*16 +: 16]), m_exh[q]);
`endif
        end
    endtask

    // Called at a negedge: drive, check combinational outputs, clock, check registered outputs.
    task automatic cycle();
        bus.enable      = en;
        bus.consumed    = cons;
        bus.cfg_valid   = cv;
        bus.cfg_period  = cper;
        bus.cfg_budgets = {cb[3], cb[2], cb[1], cb[0]};
        #1;
        obs_tick = bus.window_tick;
        check("window_tick", 32'(bus.window_tick), 32'(model_tick()));
        check("cfg_ready", 32'(bus.cfg_ready), 32'(!m_pending));
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_state();
    endtask

    task automatic offer_cfg(input int per, input int b0, input int b1, input int b2, input int b3);
        cv    = 1'b1;
        cper  = per;
        cb[0] = b0;
        cb[1] = b1;
        cb[2] = b2;
        cb[3] = b3;
        cycle();
        cv = 1'b0;
    endtask

    // Advances until the next cycle is a window-tick cycle.
    task automatic wait_tick(input string tag);
        int k;
        k = 0;
        while (!model_tick() && k < 40) begin
            cycle();
            k++;
        end
        total++;
        if (!model_tick()) begin
            bad++;
            $error("FAIL %s observed=no_tick expected=tick_within_40", tag);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        en   = 1'b1;
        cons = '0;
        cv   = 1'b0;
        cper = '0;
        for (int q = 0; q < N; q++) cb[q] = '0;
        bus.enable      = en;
        bus.consumed    = cons;
        bus.cfg_valid   = cv;
        bus.cfg_period  = cper;
        bus.cfg_budgets = '0;
        model_reset();

        // reset values while held and after release
        repeat (2) @(negedge clock);
        check("rst_tick", 32'(bus.window_tick), 0);
        check("rst_ready", 32'(bus.cfg_ready), 1);
        check("rst_throttle", 32'(bus.throttle), 0);
        check("rst_remaining0", bus.remaining[31:0], 0);
        reset = 1'b1;
        repeat (3) cycle();

        // first config applies straight away because period is 0
        offer_cfg(10, 3, 0, 1, 5);
        cycle();
        cons = 4'b0001;
        repeat (3) cycle();
        cons = 4'b0000;
        check("q0_exhausted_rem", bus.remaining[31:0], 0);
        check("q0_exhausted_thr", 32'(bus.throttle[0]), 1);
        cons = 4'b0010;
        repeat (20) cycle();
        cons = 4'b0000;
        check("q1_unlimited_thr", 32'(bus.throttle[1]), 0);
        check("q1_unlimited_rem", bus.remaining[63:32], 0);

        // consumption on the tick cycle loses to the reload
        wait_tick("wait_tick_consume");
        cons = 4'b0001;
        cycle();
        cons = 4'b0000;
        check("tick_wins_rem", bus.remaining[31:0], 3);
        check("tick_wins_thr", 32'(bus.throttle[0]), 0);

        // a fourth pulse on an exhausted queue saturates at zero
        cons = 4'b0001;
        repeat (4) cycle();
        cons = 4'b0000;
        check("saturate_rem", bus.remaining[31:0], 0);
        check("saturate_thr", 32'(bus.throttle[0]), 1);

`ifdef REGULATOR_STATS_EN
        for (int w = 0; w < 3; w++) begin
            wait_tick("wait_tick_stats");
            cycle();
            cons = 4'b0100;
            cycle();
            cons = 4'b0000;
        end
        check("stats_q2", 32'(bus.exhaust_count[47:32]), 3);
`endif

        // mid-window reconfiguration waits for the current window's boundary
        if (model_tick()) cycle();
        offer_cfg(4, 2, 1, 0, 3);
        check("pending_ready", 32'(bus.cfg_ready), 0);
        wait_tick("wait_tick_apply");
        cycle();
        check("applied_ready", 32'(bus.cfg_ready), 1);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!obs_tick && n < 20);
        check("new_period_len", n, 4);

        // random traffic, enable toggling and reconfiguration
        for (int c = 0; c < 400; c++) begin
            en   = ($urandom_range(0, 15) != 0);
            cons = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            cv   = ($urandom_range(0, 19) == 0);
            cper = $urandom_range(0, 8);
            for (int q = 0; q < N; q++) cb[q] = $urandom_range(0, 4);
            cycle();
        end
        en   = 1'b1;
        cons = 4'b0000;
        cv   = 1'b0;

        // asynchronous reset in the middle of a window clears everything immediately
        n = 0;
        while (m_pending && n < 40) begin
            cycle();
            n++;
        end
        offer_cfg(6, 2, 2, 2, 2);
        cycle();
        cons = 4'b0001;
        cycle();
        cons = 4'b0000;
        check("pre_reset_rem", bus.remaining[31:0], 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_rem", bus.remaining[31:0], 0);
        check("mid_rst_rem1", bus.remaining[63:32], 0);
        check("mid_rst_thr", 32'(bus.throttle), 0);
        check("mid_rst_ready", 32'(bus.cfg_ready), 1);
        check("mid_rst_tick", 32'(bus.window_tick), 0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (5) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
